// File: rtl/carsel_subtractor_pipe.sv
// Two-stage carry-select subtractor d = a - b - bin, valid/ready stream on both sides (optional signed overflow: CARSEL_SUB_OVF_EN).
// Latency 2 cycles; holds up to 2 results, in_ready drops only when both stages are full and out_ready is low.
module carsel_subtractor_pipe #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bo
`ifdef CARSEL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int HALF = WIDTH / 2;
    localparam int NBLK = HALF / BLOCK;

    // Ripple of block carries; each block precomputes both carry-in cases and the
    // incoming carry only drives the select mux.
    function automatic logic [HALF:0] cs_add(input logic [HALF-1:0] x,
                                             input logic [HALF-1:0] y,
                                             input logic            cin);
        logic [HALF-1:0] sum;
        logic            c;
        logic [BLOCK:0]  r0;
        logic [BLOCK:0]  r1;
        sum = '0;
        c   = cin;
        for (int i = 0; i < NBLK; i++) begin
            r0 = {1'b0, x[i*BLOCK +: BLOCK]} + {1'b0, y[i*BLOCK +: BLOCK]};
            r1 = {1'b0, x[i*BLOCK +: BLOCK]} + {1'b0, y[i*BLOCK +: BLOCK]} + (BLOCK+1)'(1);
            sum[i*BLOCK +: BLOCK] = c ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
            c = c ? r1[BLOCK] : r0[BLOCK];
        end
        return {c, sum};
    endfunction

    logic            s1_vld_q, s1_vld_d;
    logic [HALF-1:0] s1_lo_q, s1_lo_d;
    logic            s1_cmid_q, s1_cmid_d;
    logic [HALF-1:0] s1_ahi_q, s1_ahi_d;
    logic [HALF-1:0] s1_nbhi_q, s1_nbhi_d;

    logic             s2_vld_q, s2_vld_d;
    logic [WIDTH-1:0] s2_dif_q, s2_dif_d;
    logic             s2_bo_q, s2_bo_d;
`ifdef CARSEL_SUB_OVF_EN
    logic             s2_ovf_q, s2_ovf_d;
`endif

    logic            s2_adv;
    logic            s1_adv;
    logic            s1_load;
    logic            s2_load;
    logic [HALF:0]   lo_res;
    logic [HALF:0]   hi0_res;
    logic [HALF:0]   hi1_res;
    logic [HALF:0]   hi_sel;

    always_comb begin
        s2_adv  = !s2_vld_q || out_ready;
        s1_adv  = !s1_vld_q || s2_adv;
        s1_load = in_valid && s1_adv;
        s2_load = s1_vld_q && s2_adv;
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_vld_q;
    assign d         = s2_dif_q;
    assign bo        = s2_bo_q;
`ifdef CARSEL_SUB_OVF_EN
    assign ovf       = s2_ovf_q;
`endif

    // Subtraction as a + ~b + ~bin; the carry out of the low half is c_mid.
    always_comb begin
        lo_res    = cs_add(a[HALF-1:0], ~b[HALF-1:0], ~bin);
        s1_vld_d  = s1_vld_q;
        s1_lo_d   = s1_lo_q;
        s1_cmid_d = s1_cmid_q;
        s1_ahi_d  = s1_ahi_q;
        s1_nbhi_d = s1_nbhi_q;
        if (s1_adv) begin
            s1_vld_d = in_valid;
        end
        if (s1_load) begin
            s1_lo_d   = lo_res[HALF-1:0];
            s1_cmid_d = lo_res[HALF];
            s1_ahi_d  = a[WIDTH-1:HALF];
            s1_nbhi_d = ~b[WIDTH-1:HALF];
        end
    end

    always_comb begin
        hi0_res  = cs_add(s1_ahi_q, s1_nbhi_q, 1'b0);
        hi1_res  = cs_add(s1_ahi_q, s1_nbhi_q, 1'b1);
        hi_sel   = s1_cmid_q ? hi1_res : hi0_res;
        s2_vld_d = s2_vld_q;
        s2_dif_d = s2_dif_q;
        s2_bo_d  = s2_bo_q;
`ifdef CARSEL_SUB_OVF_EN
        s2_ovf_d = s2_ovf_q;
`endif
        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
        end
        if (s2_load) begin
            s2_dif_d = {hi_sel[HALF-1:0], s1_lo_q};
            s2_bo_d  = ~hi_sel[HALF];
`ifdef CARSEL_SUB_OVF_EN
            // Sign of b is recovered from the stored inverted upper half.
            s2_ovf_d = (s1_ahi_q[HALF-1] != ~s1_nbhi_q[HALF-1]) &&
                       (hi_sel[HALF-1] != s1_ahi_q[HALF-1]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_lo_q   <= '0;
            s1_cmid_q <= 1'b0;
            s1_ahi_q  <= '0;
            s1_nbhi_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_dif_q  <= '0;
            s2_bo_q   <= 1'b0;
`ifdef CARSEL_SUB_OVF_EN
            s2_ovf_q  <= 1'b0;
`endif
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_lo_q   <= s1_lo_d;
            s1_cmid_q <= s1_cmid_d;
            s1_ahi_q  <= s1_ahi_d;
            s1_nbhi_q <= s1_nbhi_d;
            s2_vld_q  <= s2_vld_d;
            s2_dif_q  <= s2_dif_d;
            s2_bo_q   <= s2_bo_d;
`ifdef CARSEL_SUB_OVF_EN
            s2_ovf_q  <= s2_ovf_d;
`endif
        end
    end

endmodule
